// File: rtl/snake_tick_pkg.sv
// rtl/snake_tick_pkg.sv - shared constants for the snake tick generator
package snake_tick_pkg;

    localparam int          SNAKE_CNT_W          = 26;
    localparam int unsigned SNAKE_DEFAULT_PERIOD = 24999999;

    // Terminal counts for the game-speed levels at 25 MHz
    localparam int unsigned SPEED_SLOW = 24999999;
    localparam int unsigned SPEED_MED  = 12499999;
    localparam int unsigned SPEED_FAST = 6249999;

    localparam int CH_MOVE = 0;
    localparam int CH_SEC  = 1;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/snake_tick_channel.sv
// rtl/snake_tick_channel.sv - one tick channel: counter, period, shadow reload
// Optional per-channel pulse counter enabled by SNAKE_TICK_COUNT_EN.
module snake_tick_channel
    import snake_tick_pkg::*;
#(
    parameter int          CNT_W          = SNAKE_CNT_W,
    parameter int unsigned DEFAULT_PERIOD = SNAKE_DEFAULT_PERIOD
) (
    input  logic             clock_25,
    input  logic             reset,
    input  logic             run,
    input  logic             clear,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_period,
    output logic             pending,
    output logic             tick_pulse,
    output logic             tick_level,
    output logic [15:0]      tick_count
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] per;
    logic [CNT_W-1:0] shadow;
    logic             wrap;

    // >= rather than == so a period lowered below cnt still wraps promptly
    assign wrap = (cnt >= per);

    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            cnt        <= '0;
            per        <= CNT_W'(DEFAULT_PERIOD);
            shadow     <= '0;
            pending    <= 1'b0;
            tick_pulse <= 1'b0;
            tick_level <= 1'b0;
        end else if (clear) begin
            cnt        <= '0;
            tick_pulse <= 1'b0;
            tick_level <= 1'b0;
            if (wr) begin
                per     <= wr_period;
                pending <= 1'b0;
            end else if (pending) begin
                per     <= shadow;
                pending <= 1'b0;
            end
        end else begin
            if (run) begin
                if (wrap) begin
                    cnt        <= '0;
                    tick_pulse <= 1'b1;
                    tick_level <= ~tick_level;
                end else begin
                    cnt        <= cnt + 1'b1;
                    tick_pulse <= 1'b0;
                end
            end else begin
                tick_pulse <= 1'b0;
            end
            if (pending && (wrap || !run)) begin
                per     <= shadow;
                pending <= 1'b0;
            end
            if (wr) begin
                shadow  <= wr_period;
                pending <= 1'b1;
            end
        end
    end

`ifdef SNAKE_TICK_COUNT_EN
    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            tick_count <= '0;
        end else if (clear) begin
            tick_count <= '0;
        end else if (run && wrap) begin
            tick_count <= sat_inc16(tick_count);
        end
    end
`else
    assign tick_count = '0;
`endif

endmodule

// File: rtl/snake_tick_gen.sv
// rtl/snake_tick_gen.sv - multi-channel programmable tick generator top
// Optional pulse counters enabled by SNAKE_TICK_COUNT_EN.
module snake_tick_gen
    import snake_tick_pkg::*;
#(
    parameter int          N_CH           = 2,
    parameter int          CNT_W          = SNAKE_CNT_W,
    parameter int unsigned DEFAULT_PERIOD = SNAKE_DEFAULT_PERIOD,
    parameter int          CH_W           = 3
) (
    input  logic               clock_25,
    input  logic               reset,
    input  logic               run,
    input  logic               clear,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [CH_W-1:0]    cfg_ch,
    input  logic [CNT_W-1:0]   cfg_period,
    output logic [N_CH-1:0]    tick_pulse,
    output logic [N_CH-1:0]    tick_level,
    output logic [N_CH*16-1:0] tick_count
);

    logic [N_CH-1:0] pending;
    logic [N_CH-1:0] wr;

    // Out-of-range channels always accept so writes to them are dropped
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < N_CH; i++) begin
            if (cfg_ch == CH_W'(i) && pending[i]) begin
                cfg_ready = 1'b0;
            end
        end
    end

    generate
        for (genvar i = 0; i < N_CH; i++) begin : g_ch
            assign wr[i] = cfg_valid & cfg_ready & (cfg_ch == CH_W'(i));

            snake_tick_channel #(
                .CNT_W          (CNT_W),
                .DEFAULT_PERIOD (DEFAULT_PERIOD)
            ) u_ch (
                .clock_25   (clock_25),
                .reset      (reset),
                .run        (run),
                .clear      (clear),
                .wr         (wr[i]),
                .wr_period  (cfg_period),
                .pending    (pending[i]),
                .tick_pulse (tick_pulse[i]),
                .tick_level (tick_level[i]),
                .tick_count (tick_count[16*i +: 16])
            );
        end
    endgenerate

endmodule
